// File: rtl/mem_pkg.sv
// Shared definitions for the parametrised data memory: operation and FSM encodings,
// plus the byte-lane helper used to size write masks.
`timescale 1ns/1ps
package mem_pkg;
   typedef enum logic {MEM_OP_RD = 1'b0, MEM_OP_WR = 1'b1} mem_op_e;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_e;

   localparam int DEFAULT_DATA_W = 32;
   localparam int BYTES          = DEFAULT_DATA_W / 8;

   function automatic int bytes_of(input int data_w);
      return data_w / 8;
   endfunction
endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: byte-masked synchronous write, combinational read.
`timescale 1ns/1ps
module dmem_array
   import mem_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 256,
   parameter     INIT_FILE = ""
)(
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   wr_idx,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [bytes_of(DATA_W)-1:0] byte_en,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [DATA_W-1:0]          rd_word
);
   localparam int NBYTES = bytes_of(DATA_W);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (byte_en[b]) begin
               mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   assign rd_word = mem[rd_idx];
endmodule

// File: rtl/data_memory_param.sv
// Word-addressed data memory with byte-enable writes, configurable access latency and
// a ready/valid handshake toward the MEM stage; out-of-range accesses flag err.
`timescale 1ns/1ps
module data_memory_param
   import mem_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int DEPTH     = 256,
   parameter int LATENCY   = 4,
   parameter     INIT_FILE = ""
)(
   input  logic                  clk,
   input  logic                  reset,
   output logic                  ready,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   byte_en,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  err
);
   localparam int NBYTES = bytes_of(DATA_W);
   localparam int OFF_W  = $clog2(NBYTES);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int TOP_W  = IDX_W + OFF_W;
   localparam int CNT_W  = $clog2(LATENCY) + 1;

   logic              accept;
   mem_op_e           req_op;
   logic [IDX_W-1:0]  req_idx;
   logic              req_oor;

   logic              comp;
   mem_op_e           comp_op;
   logic [IDX_W-1:0]  comp_idx;
   logic              comp_oor;
   logic [DATA_W-1:0] comp_wdata;
   logic [NBYTES-1:0] comp_be;

   logic              mem_we;
   logic [DATA_W-1:0] rd_word;

   assign accept  = ready & (wr_en | rd_en);
   assign req_op  = wr_en ? MEM_OP_WR : MEM_OP_RD;   // write wins when both are high
   assign req_idx = addr[TOP_W-1:OFF_W];

   generate
      if (ADDR_W > TOP_W) begin : g_range
         assign req_oor = |addr[ADDR_W-1:TOP_W];
      end else begin : g_no_range
         assign req_oor = 1'b0;
      end

      if (OFF_W > 0) begin : g_off
         logic unused_off;
         assign unused_off = &{1'b0, addr[OFF_W-1:0]};
      end

      if (LATENCY == 1) begin : g_pipe
         // Single-cycle access completes on the accept edge itself, so nothing is latched.
         assign ready      = 1'b1;
         assign comp       = accept;
         assign comp_op    = req_op;
         assign comp_idx   = req_idx;
         assign comp_oor   = req_oor;
         assign comp_wdata = wr_data;
         assign comp_be    = byte_en;
      end else begin : g_lat
         mem_state_e        state_reg;
         logic [CNT_W-1:0]  cnt_reg;
         logic              ready_reg;
         mem_op_e           op_reg;
         logic [IDX_W-1:0]  idx_reg;
         logic              oor_reg;
         logic [DATA_W-1:0] wdata_reg;
         logic [NBYTES-1:0] be_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               ready_reg <= 1'b1;
            end else begin
               case (state_reg)
                  IDLE: begin
                     if (accept) begin
                        state_reg <= BUSY;
                        cnt_reg   <= CNT_W'(1);
                        ready_reg <= 1'b0;
                     end
                  end
                  BUSY: begin
                     if (cnt_reg == CNT_W'(LATENCY - 1)) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end
                  default: state_reg <= IDLE;
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (accept) begin
               op_reg    <= req_op;
               idx_reg   <= req_idx;
               oor_reg   <= req_oor;
               wdata_reg <= wr_data;
               be_reg    <= byte_en;
            end
         end

         assign ready      = ready_reg;
         assign comp       = (state_reg == BUSY) && (cnt_reg == CNT_W'(LATENCY - 1));
         assign comp_op    = op_reg;
         assign comp_idx   = idx_reg;
         assign comp_oor   = oor_reg;
         assign comp_wdata = wdata_reg;
         assign comp_be    = be_reg;
      end
   endgenerate

   // Reset on the completion edge must still abandon the write.
   assign mem_we = comp && (comp_op == MEM_OP_WR) && !comp_oor && !reset;

   dmem_array #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk     (clk),
      .we      (mem_we),
      .wr_idx  (comp_idx),
      .wr_data (comp_wdata),
      .byte_en (comp_be),
      .rd_idx  (comp_idx),
      .rd_word (rd_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         err      <= 1'b0;
         if (comp) begin
            err <= comp_oor;
            if (comp_op == MEM_OP_RD) begin
               rd_valid <= 1'b1;
               rd_data  <= comp_oor ? '0 : rd_word;
            end
         end
      end
   end
endmodule

// File: tb/tb_data_memory_param.sv
// Scoreboard bench: a LATENCY=4 instance and a LATENCY=1 instance driven with directed
// requests; expected responses are queued at issue and matched by per-instance monitors.
`timescale 1ns/1ps
module tb_data_memory_param;
   localparam int A_DEPTH = 256;
   localparam int A_LAT   = 4;
   localparam int B_DEPTH = 16;
   localparam int B_LAT   = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        a_ready, a_wr_en, a_rd_en, a_rd_valid, a_err;
   logic [31:0] a_addr, a_wr_data, a_rd_data;
   logic [3:0]  a_byte_en;
   logic        b_ready, b_wr_en, b_rd_en, b_rd_valid, b_err;
   logic [31:0] b_addr, b_wr_data, b_rd_data;
   logic [3:0]  b_byte_en;

   data_memory_param #(.DATA_W(32), .ADDR_W(32), .DEPTH(A_DEPTH), .LATENCY(A_LAT), .INIT_FILE("")) dut_a (
      .clk(clk), .reset(rst), .ready(a_ready), .wr_en(a_wr_en), .rd_en(a_rd_en), .addr(a_addr),
      .wr_data(a_wr_data), .byte_en(a_byte_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .err(a_err));

   data_memory_param #(.DATA_W(32), .ADDR_W(32), .DEPTH(B_DEPTH), .LATENCY(B_LAT), .INIT_FILE("")) dut_b (
      .clk(clk), .reset(rst), .ready(b_ready), .wr_en(b_wr_en), .rd_en(b_rd_en), .addr(b_addr),
      .wr_data(b_wr_data), .byte_en(b_byte_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .err(b_err));

   typedef struct {
      logic        rd;
      logic [31:0] data;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   exp_t a_q[$];
   exp_t b_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Monitor for the LATENCY=4 instance.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (mon_en && !rst) begin
         if (a_q.size() > 0 && a_q[0].cyc < cyc) begin
            e = a_q.pop_front();
            checks++; errors++;
            $display("FAIL a_%s: got no response by cycle %0d required one at cycle %0d", e.name, cyc, e.cyc);
         end
         if (a_rd_valid === 1'b1 || a_err === 1'b1) begin
            checks++;
            if (a_q.size() == 0) begin
               errors++;
               $display("FAIL a_unexpected: got rd_valid=%b err=%b data=%h at cycle %0d required no response",
                        a_rd_valid, a_err, a_rd_data, cyc);
            end else begin
               e = a_q.pop_front();
               if (a_rd_valid !== e.rd || a_err !== e.err || (e.rd && a_rd_data !== e.data) || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL a_%s: got rd_valid=%b err=%b data=%h cycle=%0d required rd_valid=%b err=%b data=%h cycle=%0d",
                           e.name, a_rd_valid, a_err, a_rd_data, cyc, e.rd, e.err, e.data, e.cyc);
               end else begin
                  $display("txn a_%s: rd_valid=%b err=%b data=%h cycle=%0d", e.name, a_rd_valid, a_err, a_rd_data, cyc);
               end
            end
         end
      end
   end

   // Monitor for the LATENCY=1 instance.
   always @(negedge clk) begin : mon_b
      exp_t e;
      if (mon_en && !rst) begin
         if (b_q.size() > 0 && b_q[0].cyc < cyc) begin
            e = b_q.pop_front();
            checks++; errors++;
            $display("FAIL b_%s: got no response by cycle %0d required one at cycle %0d", e.name, cyc, e.cyc);
         end
         if (b_rd_valid === 1'b1 || b_err === 1'b1) begin
            checks++;
            if (b_q.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected: got rd_valid=%b err=%b data=%h at cycle %0d required no response",
                        b_rd_valid, b_err, b_rd_data, cyc);
            end else begin
               e = b_q.pop_front();
               if (b_rd_valid !== e.rd || b_err !== e.err || (e.rd && b_rd_data !== e.data) || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL b_%s: got rd_valid=%b err=%b data=%h cycle=%0d required rd_valid=%b err=%b data=%h cycle=%0d",
                           e.name, b_rd_valid, b_err, b_rd_data, cyc, e.rd, e.err, e.data, e.cyc);
               end else begin
                  $display("txn b_%s: rd_valid=%b err=%b data=%h cycle=%0d", e.name, b_rd_valid, b_err, b_rd_data, cyc);
               end
            end
         end
      end
   end

   // Waits (bounded) for ready, issues one request, optionally hammers the busy window.
   task automatic a_req(input logic wr, input logic rd, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [3:0] be, input logic exp_out, input logic [31:0] exp_data,
                        input logic exp_err, input bit poke, input string name);
      exp_t e;
      int n = 0;
      while (a_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (a_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL a_%s_wait: got ready=%b required 1 within 50 cycles", name, a_ready);
         return;
      end
      a_wr_en = wr; a_rd_en = rd; a_addr = ad; a_wr_data = wd; a_byte_en = be;
      if (exp_out) begin
         e.rd = rd & ~wr; e.data = exp_data; e.err = exp_err; e.cyc = cyc + A_LAT; e.name = name;
         a_q.push_back(e);
      end
      @(negedge clk);
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      for (int k = 1; k < A_LAT; k++) begin
         check({"a_", name, "_busy"}, {31'b0, a_ready}, 32'd0);
         if (poke) begin
            a_wr_en = 1'b1; a_rd_en = 1'b1; a_addr = 32'd8; a_wr_data = 32'h0BAD0BAD; a_byte_en = 4'hF;
         end
         @(negedge clk);
      end
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      check({"a_", name, "_ready"}, {31'b0, a_ready}, 32'd1);
   endtask

   // Issues a request then pulses reset while it is in flight; nothing may complete.
   task automatic a_abort(input logic wr, input logic rd, input logic [31:0] ad, input logic [31:0] wd,
                          input string name);
      a_wr_en = wr; a_rd_en = rd; a_addr = ad; a_wr_data = wd; a_byte_en = 4'hF;
      @(negedge clk);
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check({"a_", name, "_ready_after_reset"}, {31'b0, a_ready}, 32'd1);
   endtask

   task automatic b_step(input logic wr, input logic rd, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [3:0] be, input logic exp_out, input logic [31:0] exp_data,
                         input logic exp_err, input string name);
      exp_t e;
      check({"b_", name, "_ready"}, {31'b0, b_ready}, 32'd1);
      b_wr_en = wr; b_rd_en = rd; b_addr = ad; b_wr_data = wd; b_byte_en = be;
      if (exp_out) begin
         e.rd = rd & ~wr; e.data = exp_data; e.err = exp_err; e.cyc = cyc + B_LAT; e.name = name;
         b_q.push_back(e);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      a_wr_en = 1'b0; a_rd_en = 1'b0; a_addr = '0; a_wr_data = '0; a_byte_en = '0;
      b_wr_en = 1'b0; b_rd_en = 1'b0; b_addr = '0; b_wr_data = '0; b_byte_en = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("a_reset_ready",    {31'b0, a_ready},    32'd1);
      check("a_reset_rd_data",  a_rd_data,           32'd0);
      check("a_reset_rd_valid", {31'b0, a_rd_valid}, 32'd0);
      check("a_reset_err",      {31'b0, a_err},      32'd0);
      check("b_reset_rd_data",  b_rd_data,           32'd0);
      check("b_reset_rd_valid", {31'b0, b_rd_valid}, 32'd0);
      mon_en = 1'b1;

      // Basic write/read with latency 4
      a_req(1, 0, 32'd40, 32'd15, 4'hF, 0, 32'd0, 0, 0, "wr40");
      a_req(0, 1, 32'd40, 32'd0,  4'h0, 1, 32'd15, 0, 0, "rd40");

      // Byte-enable merge
      a_req(1, 0, 32'd8, 32'hAABBCCDD, 4'hF,    0, 32'd0, 0, 0, "wr8_full");
      a_req(1, 0, 32'd8, 32'h11223344, 4'b0101, 0, 32'd0, 0, 0, "wr8_mask");
      a_req(0, 1, 32'd8, 32'd0, 4'h0, 1, 32'hAA22CC44, 0, 0, "rd8_merge");

      // Requests while busy are dropped
      a_req(0, 1, 32'd8, 32'd0, 4'h0, 1, 32'hAA22CC44, 0, 1, "rd8_poked");
      a_req(0, 1, 32'd8, 32'd0, 4'h0, 1, 32'hAA22CC44, 0, 0, "rd8_after_poke");

      // Empty byte mask, both enables, ignored low address bits, top index
      a_req(1, 0, 32'd8, 32'h00000000, 4'h0, 0, 32'd0, 0, 0, "wr8_be0");
      a_req(0, 1, 32'd8, 32'd0, 4'h0, 1, 32'hAA22CC44, 0, 0, "rd8_be0");
      a_req(1, 1, 32'd40, 32'd77, 4'hF, 0, 32'd0, 0, 0, "wr_rd40_both");
      a_req(0, 1, 32'd43, 32'd0, 4'h0, 1, 32'd77, 0, 0, "rd43_lowbits");
      a_req(1, 0, 32'd1020, 32'h5A5A0FF0, 4'hF, 0, 32'd0, 0, 0, "wr1020");
      a_req(0, 1, 32'd1020, 32'd0, 4'h0, 1, 32'h5A5A0FF0, 0, 0, "rd1020");

      // Out-of-range accesses
      a_req(1, 0, 32'd0, 32'hCAFEF00D, 4'hF, 0, 32'd0, 0, 0, "wr0");
      a_req(0, 1, 32'd1024, 32'd0, 4'h0, 1, 32'd0, 1, 0, "rd_oor");
      a_req(1, 0, 32'd1024, 32'hFFFFFFFF, 4'hF, 1, 32'd0, 1, 0, "wr_oor");
      a_req(0, 1, 32'h80000010, 32'd0, 4'h0, 1, 32'd0, 1, 0, "rd_oor_msb");
      a_req(0, 1, 32'd0, 32'd0, 4'h0, 1, 32'hCAFEF00D, 0, 0, "rd0_after_oor");

      // Reset in the middle of a write and of a read
      a_req(1, 0, 32'd12, 32'h12345678, 4'hF, 0, 32'd0, 0, 0, "wr12");
      a_abort(1, 0, 32'd12, 32'hDEADBEEF, "wr12_abort");
      a_req(0, 1, 32'd12, 32'd0, 4'h0, 1, 32'h12345678, 0, 0, "rd12_after_abort");
      a_abort(0, 1, 32'd12, 32'd0, "rd12_abort");
      a_req(0, 1, 32'd12, 32'd0, 4'h0, 1, 32'h12345678, 0, 0, "rd12_final");

      // LATENCY=1: back-to-back requests every cycle
      b_step(1, 0, 32'd20, 32'h55AA55AA, 4'hF,    0, 32'd0, 0, "wr20");
      b_step(0, 1, 32'd20, 32'd0,        4'h0,    1, 32'h55AA55AA, 0, "rd20_raw");
      b_step(1, 0, 32'd20, 32'h01020304, 4'b0011, 0, 32'd0, 0, "wr20_mask");
      b_step(0, 1, 32'd20, 32'd0,        4'h0,    1, 32'h55AA0304, 0, "rd20_mask");
      b_step(0, 1, 32'd64, 32'd0,        4'h0,    1, 32'd0, 1, "rd_oor");
      b_step(1, 1, 32'd24, 32'h00000099, 4'hF,    0, 32'd0, 0, "both24");
      b_step(0, 1, 32'd24, 32'd0,        4'h0,    1, 32'h00000099, 0, "rd24");
      b_wr_en = 1'b0; b_rd_en = 1'b0;

      repeat (8) @(negedge clk);
      checks++;
      if (a_q.size() != 0 || b_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d responses outstanding required 0/0", a_q.size(), b_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
